// File: rtl/ag_w_ctrl_if.sv
// rtl/ag_w_ctrl_if.sv - start/done handshake and W_i RAM address bus for the weight address generator
interface ag_w_ctrl_if #(
    parameter int FEATURE_BITS = 4
);
    logic                        start;
    logic                        done;
    logic [2*FEATURE_BITS-1:0]   address;
    logic [FEATURE_BITS-2:0]     cs;

    modport master (
        output start,
        input  done,
        input  address,
        input  cs
    );

    modport slave (
        input  start,
        output done,
        output address,
        output cs
    );
endinterface

// File: rtl/ag_w_ctrl.sv
// rtl/ag_w_ctrl.sv - weight address generator: sweeps every (cs, address) pair of the W_i RAMs once per start
module ag_w_ctrl #(
    parameter int FEATURE_BITS = 4
) (
    input  logic         sys_clk,
    input  logic         reset_n,
    ag_w_ctrl_if.slave   bus
);
    localparam int AW = 2 * FEATURE_BITS;
    localparam int CW = FEATURE_BITS - 1;

    localparam logic [AW-1:0] ADDR_LAST = '1;
    localparam logic [CW-1:0] CS_LAST   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_address;
    logic [CW-1:0]   r_cs;
    logic            r_done;

    state_t          w_next_state;
    logic [AW-1:0]   w_next_address;
    logic [CW-1:0]   w_next_cs;
    logic            w_next_done;
    logic            w_addr_last;
    logic            w_cs_last;

    assign w_addr_last = (r_address == ADDR_LAST);
    assign w_cs_last   = (r_cs == CS_LAST);

    // reset_n is active-high despite its name
    always_ff @(posedge sys_clk or posedge reset_n) begin
        if (reset_n) begin
            r_state   <= IDLE;
            r_address <= '0;
            r_cs      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_address <= w_next_address;
            r_cs      <= w_next_cs;
            r_done    <= w_next_done;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_address = r_address;
        w_next_cs      = r_cs;
        w_next_done    = 1'b0;

        case (r_state)
            IDLE: begin
                // the first RUN cycle presents (0, 0), so entering RUN keeps the counters cleared
                w_next_address = '0;
                w_next_cs      = '0;
                if (bus.start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_addr_last && w_cs_last) begin
                    w_next_state   = FINISH;
                    w_next_address = '0;
                    w_next_cs      = '0;
                    w_next_done    = 1'b1;
                end else if (w_addr_last) begin
                    w_next_address = '0;
                    w_next_cs      = r_cs + 1'b1;
                end else begin
                    w_next_address = r_address + 1'b1;
                end
            end
            FINISH: begin
                w_next_state   = IDLE;
                w_next_address = '0;
                w_next_cs      = '0;
            end
            default: begin
                w_next_state   = IDLE;
                w_next_address = '0;
                w_next_cs      = '0;
            end
        endcase
    end

    assign bus.address = r_address;
    assign bus.cs      = r_cs;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_ag_w_ctrl.sv
// tb/tb_ag_w_ctrl.sv - directed self-checking bench for ag_w_ctrl
module tb_ag_w_ctrl;
    localparam int FB = 4;

    logic sys_clk;
    logic reset_n;
    int   total;
    int   bad;
    logic [7:0] exp_a;
    logic [2:0] exp_c;

    ag_w_ctrl_if #(.FEATURE_BITS(FB)) bus_if ();

    ag_w_ctrl #(.FEATURE_BITS(FB)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            bus_if.start = (c == 0);
            tick();
            total++;
            if (bus_if.address !== 8'd0) begin
                bad++;
                $display("FAIL reset_addr[%0d]: got %0d expected 0", c, bus_if.address);
            end
            total++;
            if (bus_if.cs !== 3'd0) begin
                bad++;
                $display("FAIL reset_cs[%0d]: got %0d expected 0", c, bus_if.cs);
            end
            total++;
            if (bus_if.done !== 1'b0) begin
                bad++;
                $display("FAIL reset_done[%0d]: got %b expected 0", c, bus_if.done);
            end
        end
        reset_n = 1'b0;
        bus_if.start = 1'b0;
        tick();
        tick();
        total++;
        if (bus_if.address !== 8'd0 || bus_if.cs !== 3'd0 || bus_if.done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_release: got addr=%0d cs=%0d done=%b expected 0/0/0",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
    endtask

    task automatic test_full_sweep;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            exp_a = i[7:0];
            exp_c = i[10:8];
            total++;
            if (bus_if.address !== exp_a || bus_if.cs !== exp_c || bus_if.done !== 1'b0) begin
                bad++;
                $display("FAIL sweep[E%0d]: got addr=%0d cs=%0d done=%b expected %0d/%0d/0",
                         i, bus_if.address, bus_if.cs, bus_if.done, exp_a, exp_c);
            end
            tick();
        end
        total++;
        if (bus_if.done !== 1'b1 || bus_if.address !== 8'd0 || bus_if.cs !== 3'd0) begin
            bad++;
            $display("FAIL sweep_done[E2048]: got addr=%0d cs=%0d done=%b expected 0/0/1",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
        tick();
        total++;
        if (bus_if.done !== 1'b0 || bus_if.address !== 8'd0 || bus_if.cs !== 3'd0) begin
            bad++;
            $display("FAIL sweep_finish_exit[E2049]: got addr=%0d cs=%0d done=%b expected 0/0/0",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
        tick();
        total++;
        if (bus_if.done !== 1'b0 || bus_if.address !== 8'd0 || bus_if.cs !== 3'd0) begin
            bad++;
            $display("FAIL sweep_idle[E2050]: got addr=%0d cs=%0d done=%b expected 0/0/0",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        int first_done;
        int second_done;
        pulses      = 0;
        first_done  = -1;
        second_done = -1;
        bus_if.start = 1'b1;
        for (int i = 0; i < 4100; i++) begin
            tick();
            if (bus_if.done === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
            if (i == 2051) begin
                total++;
                if (bus_if.address !== 8'd1 || bus_if.cs !== 3'd0) begin
                    bad++;
                    $display("FAIL b2b_restart[E2051]: got addr=%0d cs=%0d expected 1/0",
                             bus_if.address, bus_if.cs);
                end
            end
        end
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        end
        total++;
        if (first_done !== 2048) begin
            bad++;
            $display("FAIL b2b_first_done: got E%0d expected E2048", first_done);
        end
        total++;
        if (second_done !== 4098) begin
            bad++;
            $display("FAIL b2b_second_done: got E%0d expected E4098", second_done);
        end
        bus_if.start = 1'b0;
        tick();
        total++;
        if (bus_if.done !== 1'b0 || bus_if.address !== 8'd0 || bus_if.cs !== 3'd0) begin
            bad++;
            $display("FAIL b2b_idle: got addr=%0d cs=%0d done=%b expected 0/0/0",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int busy;
        busy = 0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        repeat (868) tick();
        total++;
        if (bus_if.address !== 8'd100 || bus_if.cs !== 3'd3) begin
            bad++;
            $display("FAIL mid_position[E868]: got addr=%0d cs=%0d expected 100/3",
                     bus_if.address, bus_if.cs);
        end
        #2;
        reset_n = 1'b1;
        #1;
        total++;
        if (bus_if.address !== 8'd0 || bus_if.cs !== 3'd0 || bus_if.done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got addr=%0d cs=%0d done=%b expected 0/0/0",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
        tick();
        reset_n = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            tick();
            if (bus_if.done !== 1'b0 || bus_if.address !== 8'd0 || bus_if.cs !== 3'd0) busy++;
        end
        total++;
        if (busy !== 0) begin
            bad++;
            $display("FAIL post_reset_quiet: got %0d active cycles expected 0", busy);
        end
    endtask

    task automatic test_start_during_run;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            exp_a = i[7:0];
            exp_c = i[10:8];
            total++;
            if (bus_if.address !== exp_a || bus_if.cs !== exp_c || bus_if.done !== 1'b0) begin
                bad++;
                $display("FAIL run_start[E%0d]: got addr=%0d cs=%0d done=%b expected %0d/%0d/0",
                         i, bus_if.address, bus_if.cs, bus_if.done, exp_a, exp_c);
            end
            bus_if.start = (i == 512);
            tick();
        end
        total++;
        if (bus_if.done !== 1'b1 || bus_if.address !== 8'd0 || bus_if.cs !== 3'd0) begin
            bad++;
            $display("FAIL run_start_done[E2048]: got addr=%0d cs=%0d done=%b expected 0/0/1",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
        tick();
        tick();
        total++;
        if (bus_if.done !== 1'b0 || bus_if.address !== 8'd0 || bus_if.cs !== 3'd0) begin
            bad++;
            $display("FAIL run_start_idle[E2050]: got addr=%0d cs=%0d done=%b expected 0/0/0",
                     bus_if.address, bus_if.cs, bus_if.done);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b1;
        bus_if.start = 1'b0;
        test_reset();
        test_full_sweep();
        test_back_to_back();
        test_reset_mid_sweep();
        test_start_during_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ag_w_ctrl.md
AG_W_CTRL -- requirements
Module: ag_w

Interface
REQ-001 The block SHALL have parameter FEATURE_BITS, default 4, the log2 of the feature dimension (N = 2^FEATURE_BITS rows and columns per weight matrix).
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the systolic array clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: the asynchronous, active-high reset (1 = reset, despite the name).
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one full weight-address sweep.
REQ-005 The block SHALL have port done, output, 1 bit: one-cycle pulse marking completion of a sweep.
REQ-006 The block SHALL have port address, output, 2*FEATURE_BITS bits: word address into the selected W_i dual-port RAM.
REQ-007 The block SHALL have port cs, output, FEATURE_BITS-1 bits: chip select (index) of the W_i dual-port RAM being addressed.
REQ-008 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, RUN and FINISH.
REQ-010 In IDLE, the block SHALL drive address=0, cs=0 and done=0.
REQ-011 In IDLE, start=1 at a rising edge SHALL move the FSM to RUN, with address=0 and cs=0 valid from that edge.
REQ-012 In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-013 In RUN, each rising edge SHALL increment address by 1, giving a 1-cycle issue rate.
REQ-014 In RUN, when address = 2^(2*FEATURE_BITS)-1 and cs < 2^(FEATURE_BITS-1)-1, the next edge SHALL wrap address to 0 and increment cs by 1.
REQ-015 In RUN, when address and cs are both all-ones, the next edge SHALL enter FINISH with address=0, cs=0 and done=1.
REQ-016 FINISH SHALL last exactly one cycle and then return to IDLE with done=0, whatever the value of start.
REQ-017 start SHALL be ignored in RUN and in FINISH; a new sweep requires start=1 to be sampled in IDLE.
REQ-018 A sweep SHALL present every (cs, address) pair exactly once, in cs-major, address-minor ascending order.
REQ-019 For the default parameters, a sweep SHALL cover 8 x 256 = 2048 RUN cycles.
REQ-020 Counters SHALL never exceed their field widths, and no wrap of cs SHALL occur in RUN.

Reset
REQ-021 While reset_n=1, asynchronously and regardless of the clock, the block SHALL force state=IDLE, address=0, cs=0 and done=0.
REQ-022 Reset asserted mid-sweep SHALL abort the sweep, with no done pulse generated.
REQ-023 After reset_n falls to 0, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-024 The bench SHALL hold reset_n=1 for two cycles, with start toggling -> address=0, cs=0, done=0 throughout.
REQ-025 The bench SHALL release reset and pulse start for one cycle at edge E0 -> after E0 address=0, cs=0; after E1 address=1; after E255 address=255, cs=0; after E256 address=0, cs=1.
REQ-026 For a full sweep with start sampled at E0 -> after E2047 address=255, cs=7; after E2048 done=1, address=0, cs=0; after E2049 done=0, state IDLE; done high for exactly one cycle.
REQ-027 Holding start=1 continuously -> sweeps repeat, with done pulsing once every 2050 cycles.
REQ-028 Asserting reset_n=1 mid-sweep (for example at address=100, cs=3) -> outputs become 0 immediately without a clock edge; after release, with start=0, outputs stay 0 and no done is seen.
REQ-029 Pulsing start during RUN (for example at cs=2) -> the address sequence is unaffected and done still occurs at E2048.
